sad_multi: RTL and testbench

Parametrised sum-of-absolute-differences (SAD) trigger core for the `clk_adc` domain, the next generation of the single-shot SAD trigger. Every ADC sample it scores the sliding window of the last `pREF_SAMPLES` samples against a stored reference with a per-sample mask, and pulses `trigger` when the score is below a runtime threshold. Additions over the single-shot trigger:
- multi-trigger mode with holdoff;
- arm-aligned window eligibility;
- captured score and trigger count;
- reference-write protection while armed.

It sits between the ADC input register and the trigger mux. Its register-side ports are driven by the USB register block, already synchronised to `clk_adc`.

---
 rtl/sad_multi.sv | 196 +++++++++++++++++++
 tb/tb_sad_multi.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_multi.sv
// sad_multi: sliding-window SAD trigger with multi-shot holdoff,
// arm-aligned window eligibility and a write-protected reference.
module sad_multi #(
   parameter int pREF_SAMPLES     = 32,
   parameter int pBITS_PER_SAMPLE = 12,
   parameter int pSCORE_W         = pBITS_PER_SAMPLE + $clog2(pREF_SAMPLES)
) (
   input  logic                            clk_adc,
   input  logic                            reset,
   input  logic                            arm_i,
   input  logic [pBITS_PER_SAMPLE-1:0]     adc_datain,
   input  logic                            ref_we,
   input  logic [$clog2(pREF_SAMPLES)-1:0] ref_addr,
   input  logic [pBITS_PER_SAMPLE-1:0]     ref_wdata,
   input  logic                            ref_mask_wdata,
   input  logic [31:0]                     threshold,
   input  logic                            multi_trigger,
   input  logic [15:0]                     holdoff,
   input  logic                            status_clear,
   output logic                            trigger,
   output logic                            armed,
   output logic [pSCORE_W-1:0]             score,
   output logic [15:0]                     trigger_count,
   output logic                            write_rejected
);

   localparam int N  = pREF_SAMPLES;
   localparam int B  = pBITS_PER_SAMPLE;
   localparam int SW = pSCORE_W;
   localparam int FW = $clog2(N + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ACTIVE,
      S_HOLD,
      S_DONE
   } state_t;

   state_t          r_state;
   logic [B-1:0]    r_ref [N];
   logic [N-1:0]    r_mask;
   logic [B-1:0]    r_din;
   logic [SW-1:0]   r_acc [N-1];
   logic [SW-1:0]   r_win;
   logic [SW-1:0]   r_hscore;
   logic            r_ev;
   logic            r_wv;
   logic            r_hit;
   logic [FW-1:0]   r_fill;
   logic [15:0]     r_hcnt;
   logic            r_trig;
   logic            r_armed;
   logic [SW-1:0]   r_score;
   logic [15:0]     r_cnt;
   logic            r_wrej;

   logic [B-1:0]    w_diff [N];
   logic            w_live;
   logic            w_fire;
   logic            w_start;
   logic            w_idle;

   assign w_idle  = (r_state == S_IDLE);
   assign w_live  = arm_i && !w_idle;
   assign w_start = arm_i && w_idle;
   assign w_fire  = arm_i && (r_state == S_ACTIVE) && r_hit;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         w_diff[k] = '0;
         if (r_mask[k])
            w_diff[k] = (r_din >= r_ref[k]) ? r_din - r_ref[k]
                                            : r_ref[k] - r_din;
      end
   end

   always_ff @(posedge clk_adc) begin
      if (reset) begin
         r_mask <= '0;
         for (int k = 0; k < N; k++)
            r_ref[k] <= '0;
      end else if (ref_we && w_idle) begin
         r_ref[ref_addr]  <= ref_wdata;
         r_mask[ref_addr] <= ref_mask_wdata;
      end
   end

   // Partial sums shift one slot per sample; slot k holds a window
   // that has absorbed k+1 samples, so r_win is a full window each cycle.
   always_ff @(posedge clk_adc) begin
      if (reset) begin
         r_din    <= '0;
         r_win    <= '0;
         r_hscore <= '0;
         r_ev     <= 1'b0;
         r_wv     <= 1'b0;
         r_hit    <= 1'b0;
         for (int k = 0; k < N - 1; k++)
            r_acc[k] <= '0;
      end else begin
         r_din    <= adc_datain;
         r_acc[0] <= SW'(w_diff[0]);
         for (int k = 1; k < N - 1; k++)
            r_acc[k] <= r_acc[k-1] + SW'(w_diff[k]);
         r_win    <= r_acc[N-2] + SW'(w_diff[N-1]);
         r_ev     <= w_live && (r_fill >= FW'(N - 1));
         r_wv     <= arm_i && r_ev;
         r_hit    <= arm_i && r_wv && (32'(r_win) < threshold);
         r_hscore <= r_win;
      end
   end

   always_ff @(posedge clk_adc) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_fill  <= '0;
         r_hcnt  <= '0;
         r_trig  <= 1'b0;
         r_armed <= 1'b0;
         r_score <= '0;
      end else begin
         r_trig <= 1'b0;
         if (!w_live)
            r_fill <= '0;
         else if (r_fill != FW'(N))
            r_fill <= r_fill + 1'b1;
         if (!arm_i) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  r_state <= S_FILL;
                  r_armed <= 1'b1;
               end
               S_FILL: begin
                  if (r_fill == FW'(N - 1))
                     r_state <= S_ACTIVE;
               end
               S_ACTIVE: begin
                  if (r_hit) begin
                     r_trig  <= 1'b1;
                     r_score <= r_hscore;
                     if (!multi_trigger) begin
                        r_state <= S_DONE;
                        r_armed <= 1'b0;
                     end else if (holdoff != 16'd0) begin
                        r_state <= S_HOLD;
                        r_hcnt  <= 16'd1;
                     end
                  end
               end
               S_HOLD: begin
                  if (r_hcnt >= holdoff)
                     r_state <= S_ACTIVE;
                  else
                     r_hcnt <= r_hcnt + 16'd1;
               end
               S_DONE: begin
                  r_state <= S_DONE;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_armed <= 1'b0;
               end
            endcase
         end
      end
   end

   // A set or increment in the same cycle as a clear takes priority.
   always_ff @(posedge clk_adc) begin
      if (reset) begin
         r_cnt  <= '0;
         r_wrej <= 1'b0;
      end else begin
         if (w_fire)
            r_cnt <= status_clear ? 16'd1 :
                     (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
         else if (w_start || status_clear)
            r_cnt <= '0;
         if (ref_we && !w_idle)
            r_wrej <= 1'b1;
         else if (status_clear)
            r_wrej <= 1'b0;
      end
   end

   assign trigger        = r_trig;
   assign armed          = r_armed;
   assign score          = r_score;
   assign trigger_count  = r_cnt;
   assign write_rejected = r_wrej;

endmodule

// File: tb/tb_sad_multi.sv
// Bench for sad_multi (N=8, B=12): window-level reference model
// compared every cycle, plus directed literal checks per scenario.
module tb_sad_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic        arm_i;
   logic [11:0] adc_datain;
   logic        ref_we;
   logic [2:0]  ref_addr;
   logic [11:0] ref_wdata;
   logic        ref_mask_wdata;
   logic [31:0] threshold;
   logic        multi_trigger;
   logic [15:0] holdoff;
   logic        status_clear;
   logic        trigger;
   logic        armed;
   logic [14:0] score;
   logic [15:0] trigger_count;
   logic        write_rejected;

   sad_multi #(.pREF_SAMPLES(8), .pBITS_PER_SAMPLE(12)) dut (
      .clk_adc(clk), .reset(reset), .arm_i(arm_i),
      .adc_datain(adc_datain), .ref_we(ref_we), .ref_addr(ref_addr),
      .ref_wdata(ref_wdata), .ref_mask_wdata(ref_mask_wdata),
      .threshold(threshold), .multi_trigger(multi_trigger),
      .holdoff(holdoff), .status_clear(status_clear),
      .trigger(trigger), .armed(armed), .score(score),
      .trigger_count(trigger_count), .write_rejected(write_rejected)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int trig_seen = 0;
   int first_trig = -1;
   int last_trig = -1;

   int   hist [0:8191];
   int   thr_hist [0:8191];
   int   m_ref [8];
   bit   m_mask [8];
   int   m_arm = -1;
   bit   m_done = 1'b0;
   int   m_hold = 0;
   int   m_cnt = 0;
   int   m_score = 0;
   bit   m_wrej = 1'b0;
   bit   m_trig = 1'b0;
   bit   m_armed = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d edge=%0d",
                    name, act, exp, cyc);
   endtask

   function automatic int window_score(input int n);
      int s;
      int d;
      s = 0;
      for (int k = 0; k < 8; k++) begin
         d = hist[n - 7 + k] - m_ref[k];
         if (d < 0) d = -d;
         if (m_mask[k]) s += d;
      end
      return s;
   endfunction

   // Reference model: decides each edge what the outputs must read after it.
   always @(posedge clk) begin : model
      int  n;
      int  sc;
      bit  fire;
      bit  rej;
      cyc++;
      if (cyc < 8192) begin
         hist[cyc]     = int'(adc_datain);
         thr_hist[cyc] = int'(threshold);
      end
      fire = 1'b0;
      rej  = 1'b0;
      if (reset) begin
         for (int k = 0; k < 8; k++) begin
            m_ref[k]  = 0;
            m_mask[k] = 1'b0;
         end
         m_arm = -1; m_done = 1'b0; m_hold = 0; m_cnt = 0;
         m_score = 0; m_wrej = 1'b0; m_trig = 1'b0; m_armed = 1'b0;
      end else begin
         if (ref_we) begin
            if (m_arm < 0) begin
               m_ref[ref_addr]  = int'(ref_wdata);
               m_mask[ref_addr] = ref_mask_wdata;
            end else rej = 1'b1;
         end
         if (!arm_i) m_arm = -1;
         else if (m_arm < 0) begin
            m_arm = cyc; m_done = 1'b0; m_hold = 0; m_cnt = 0;
         end else if (!m_done) begin
            n = cyc - 3;
            if (m_hold > 0) m_hold--;
            else if (n >= m_arm + 8) begin
               sc = window_score(n);
               if (longint'(sc) < longint'(unsigned'(thr_hist[cyc-1]))) begin
                  fire = 1'b1;
                  m_score = sc;
                  if (!multi_trigger) m_done = 1'b1;
                  else m_hold = int'(holdoff);
               end
            end
         end
         m_trig = fire;
         if (fire) m_cnt = status_clear ? 1 : (m_cnt == 65535 ? 65535 : m_cnt + 1);
         else if (status_clear) m_cnt = 0;
         if (rej) m_wrej = 1'b1;
         else if (status_clear) m_wrej = 1'b0;
         m_armed = (m_arm >= 0) && !m_done;
      end
   end

   always @(negedge clk) begin
      if (cyc > 0) begin
         chk("trigger", int'(trigger), int'(m_trig));
         chk("armed", int'(armed), int'(m_armed));
         chk("score", int'(score), m_score);
         chk("trigger_count", int'(trigger_count), m_cnt);
         chk("write_rejected", int'(write_rejected), int'(m_wrej));
         if (trigger) begin
            if (trig_seen == 0) first_trig = cyc;
            trig_seen++;
            last_trig = cyc;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic feed(input int d);
      adc_datain = 12'(d);
      step();
   endtask

   task automatic wr(input int a, input int d, input bit m);
      ref_we = 1'b1; ref_addr = 3'(a); ref_wdata = 12'(d); ref_mask_wdata = m;
      step();
      ref_we = 1'b0;
   endtask

   task automatic load_ref(input bit m);
      for (int k = 0; k < 8; k++) wr(k, (k + 1) * 100, m);
   endtask

   task automatic feed_ref(input int idx, input int val);
      for (int k = 0; k < 8; k++) feed(k == idx ? val : (k + 1) * 100);
   endtask

   task automatic arm_now(output int a);
      arm_i = 1'b1;
      trig_seen = 0;
      first_trig = -1;
      feed(0);
      a = cyc;
   endtask

   task automatic disarm();
      arm_i = 1'b0;
      feed(0);
      feed(0);
   endtask

   int a;

   initial begin
      reset = 1'b1; arm_i = 1'b0; adc_datain = '0; ref_we = 1'b0;
      ref_addr = '0; ref_wdata = '0; ref_mask_wdata = 1'b0;
      threshold = '0; multi_trigger = 1'b0; holdoff = '0; status_clear = 1'b0;
      repeat (3) step();
      chk("rst_trigger", int'(trigger), 0);
      chk("rst_armed", int'(armed), 0);
      chk("rst_score", int'(score), 0);
      chk("rst_count", int'(trigger_count), 0);
      chk("rst_wrej", int'(write_rejected), 0);
      reset = 1'b0;
      step();

      // exact match after 5 random samples
      load_ref(1'b1);
      threshold = 10;
      arm_now(a);
      repeat (5) feed(int'($urandom_range(0, 4095)));
      feed_ref(-1, 0);
      repeat (6) feed(0);
      chk("t1_pulses", trig_seen, 1);
      chk("t1_edge", last_trig, a + 16);
      chk("t1_score", int'(score), 0);
      chk("t1_count", int'(trigger_count), 1);
      chk("t1_done_armed", int'(armed), 0);
      disarm();

      // threshold edge
      threshold = 9;
      arm_now(a);
      repeat (8) feed(0);
      feed_ref(3, 409);
      repeat (4) feed(0);
      chk("t2_no_trig", trig_seen, 0);
      feed_ref(3, 408);
      repeat (5) feed(0);
      chk("t2_pulses", trig_seen, 1);
      chk("t2_score", int'(score), 8);
      disarm();

      // masked index
      wr(5, 600, 1'b0);
      threshold = 1;
      arm_now(a);
      repeat (8) feed(0);
      feed_ref(5, 4095);
      repeat (5) feed(0);
      chk("t3_pulses", trig_seen, 1);
      chk("t3_score", int'(score), 0);
      disarm();

      // multi-trigger with holdoff=3, then holdoff=0, then threshold=0
      load_ref(1'b0);
      multi_trigger = 1'b1; holdoff = 3; threshold = 1;
      arm_now(a);
      repeat (24) feed(int'($urandom_range(0, 4095)));
      chk("t4_first", first_trig, a + 11);
      chk("t4_pulses", trig_seen, 4);
      chk("t4_count", int'(trigger_count), 4);
      disarm();
      holdoff = 0;
      arm_now(a);
      repeat (14) feed(int'($urandom_range(0, 4095)));
      chk("t4b_pulses", trig_seen, 4);
      chk("t4b_count", int'(trigger_count), 4);
      disarm();
      threshold = 0;
      arm_now(a);
      repeat (14) feed(int'($urandom_range(0, 4095)));
      chk("t4c_pulses", trig_seen, 0);
      disarm();

      // arm alignment
      load_ref(1'b1);
      multi_trigger = 1'b0; threshold = 10;
      arm_i = 1'b1; trig_seen = 0;
      feed(100);
      for (int k = 1; k < 8; k++) feed((k + 1) * 100);
      repeat (6) feed(0);
      chk("t5_early", trig_seen, 0);
      disarm();
      arm_now(a);
      feed_ref(-1, 0);
      repeat (5) feed(0);
      chk("t5_pulses", trig_seen, 1);
      chk("t5_edge", last_trig, a + 11);
      disarm();

      // write protection, clear priority, disarm mid-FILL, reset mid-ACTIVE
      arm_now(a);
      repeat (10) feed(0);
      wr(2, 0, 1'b1);
      chk("t6_wrej", int'(write_rejected), 1);
      feed_ref(-1, 0);
      repeat (5) feed(0);
      chk("t6_ref_kept", int'(score), 0);
      chk("t6_pulses", trig_seen, 1);
      status_clear = 1'b1;
      feed(0);
      status_clear = 1'b0;
      chk("t6_clr_wrej", int'(write_rejected), 0);
      chk("t6_clr_count", int'(trigger_count), 0);
      status_clear = 1'b1;
      wr(1, 0, 1'b1);
      status_clear = 1'b0;
      chk("t6_set_wins", int'(write_rejected), 1);
      disarm();
      arm_now(a);
      repeat (3) feed(0);
      arm_i = 1'b0;
      feed(0);
      chk("t6_fill_drop", int'(armed), 0);
      repeat (4) feed(0);
      chk("t6_fill_notrig", trig_seen, 0);
      arm_now(a);
      repeat (8) feed(0);
      feed_ref(-1, 0);
      reset = 1'b1;
      feed(0);
      reset = 1'b0;
      chk("t6_rst_armed", int'(armed), 0);
      repeat (4) feed(0);
      chk("t6_rst_notrig", trig_seen, 0);
      disarm();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
